// File: rtl/addsub_sched_pkg.sv
// Shared definitions for the add_sub round-robin scheduler.
//   DW / RW        : operand width and add_sub result width (carry included)
//   sched_state_t  : scheduler FSM states
//   ovf_f          : two's complement overflow of the low DW bits of a result
package addsub_sched_pkg;

    localparam int DW = 8;
    localparam int RW = DW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    // Arguments are the sign bits only: a, b, the sub control and result bit DW-1.
    // For a subtract the effective second operand sign is b ^ sub.
    function automatic logic ovf_f(input logic a, input logic b, input logic sub, input logic s);
        return (a == (b ^ sub)) && (s != a);
    endfunction

endpackage

// File: rtl/addsub_rr_sched_if.sv
// Requester / response bundle of the add_sub scheduler.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed 8-bit operands, requester i at [8*i+7:8*i]
//   req_sub             : per-requester operation, 0 = A+B, 1 = A-B
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_sum/rsp_ovf : owner id, 9-bit result, signed overflow
//   busy                : scheduler not idle
// slave = scheduler side, master = requester/consumer side.
interface addsub_rr_sched_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [8:0]        rsp_sum;
    logic              rsp_ovf;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
    );
endinterface

// File: rtl/add_sub.sv
// Shared 8-bit adder/subtractor.
//   A, B      : operands
//   addsuben  : 0 = A+B, 1 = A-B
//   S         : {carry, sum}; for subtract S[8] is the no-borrow flag (A >= B)
module add_sub (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       addsuben,
    output logic [8:0] S
);
    logic [7:0] b_eff;

    always_comb begin
        b_eff = addsuben ? ~B : B;
        S     = {1'b0, A} + {1'b0, b_eff} + {8'd0, addsuben};
    end
endmodule

// File: rtl/addsub_rr_sched_rr_pick.sv
// Combinational rotate-priority encoder.
//   req        : request vector
//   ptr        : index with highest priority this cycle (0..N-1)
//   gnt_onehot : one-hot winner (zero when no request)
//   gnt_idx    : winner index
//   any        : at least one request
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [SW-1:0] pos;
    logic [IW-1:0] idx;

    // Scan ptr, ptr+1, ... with an explicit wrap so that non power-of-two N works.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        pos        = '0;
        idx        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = {1'b0, ptr} + SW'(off);
            if (pos >= SW'(N)) begin
                pos = pos - SW'(N);
            end
            idx = pos[IW-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one add_sub among NREQ requesters.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of addsub_rr_sched_if (request handshake, operands,
//          result handshake, busy)
// Flow: IDLE grants one requester and registers its operands, CALC drives
// add_sub and registers the result, HOLD presents it until rsp_ready.
module addsub_rr_sched
    import addsub_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    addsub_rr_sched_if.slave    bus
);
    localparam int IDW = $clog2(NREQ);

    sched_state_t   state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic           sub_q, sub_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [RW-1:0]  rsp_sum_q, rsp_sum_d;
    logic           rsp_ovf_q, rsp_ovf_d;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [DW-1:0]   a_sel, b_sel;
    logic            sub_sel;
    logic [RW-1:0]   s;

    rr_pick #(.N(NREQ)) u_pick (
        .req        (bus.req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    add_sub u_add_sub (
        .A        (a_q),
        .B        (b_q),
        .addsuben (sub_q),
        .S        (s)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_onehot[i]) begin
                a_sel   = bus.req_a[DW*i +: DW];
                b_sel   = bus.req_b[DW*i +: DW];
                sub_sel = bus.req_sub[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovf_d   = rsp_ovf_q;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_d      = a_sel;
                    b_d      = b_sel;
                    sub_d    = sub_sel;
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = s;
                rsp_id_d    = id_q;
                rsp_ovf_d   = ovf_f(a_q[DW-1], b_q[DW-1], sub_q, s[DW-1]);
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    // Grant is offered only while idle; it never depends on rsp_ready.
    assign bus.req_ready = (state_q == IDLE) ? gnt_onehot : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_addsub_rr_sched.sv
// Bench for addsub_rr_sched: directed cases with literal expectations plus a
// randomized run, all outputs compared each cycle against a transaction-level model.
module tb_addsub_rr_sched;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_rr_sched_if #(.NREQ(NREQ)) bus ();

    addsub_rr_sched #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase = 0;   // 0 idle, 1 operation accepted, 2 result presented
    int m_ptr   = 0;
    int m_id = 0, m_a = 0, m_b = 0, m_sub = 0, m_sum = 0, m_ovf = 0;
    int issued = 0, answered = 0, dropped = 0;

    function automatic void model_result(input int a, input int b, input int sub,
                                         output int sum, output int ovf);
        int sa, sb, r;
        if (sub == 0) sum = a + b;
        else          sum = ((a - b) & 255) | ((a >= b) ? 256 : 0);
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        r   = (sub != 0) ? sa - sb : sa + sb;
        ovf = (r > 127 || r < -128) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        int g, i;
        if (rst) begin
            if (m_phase != 0) dropped++;
            m_phase = 0;
            m_ptr   = 0;
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_sum", bus.rsp_sum, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_ovf", bus.rsp_ovf, 0);
        end else begin
            exp_ready = '0;
            g = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    i = (m_ptr + k) % NREQ;
                    if (g < 0 && bus.req_valid[i]) g = i;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", bus.busy, m_phase != 0);
            chk("rsp_valid", bus.rsp_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("rsp_id", bus.rsp_id, m_id);
                chk("rsp_sum", bus.rsp_sum, m_sum);
                chk("rsp_ovf", bus.rsp_ovf, m_ovf);
            end
            case (m_phase)
                0: if (g >= 0) begin
                    m_id    = g;
                    m_a     = bus.req_a[8*g +: 8];
                    m_b     = bus.req_b[8*g +: 8];
                    m_sub   = bus.req_sub[g];
                    m_ptr   = (g + 1) % NREQ;
                    m_phase = 1;
                    issued++;
                end
                1: begin
                    model_result(m_a, m_b, m_sub, m_sum, m_ovf);
                    m_phase = 2;
                end
                default: if (bus.rsp_ready) begin
                    m_phase = 0;
                    answered++;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", bus.busy, 0);
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [8:0] es, input logic eo);
        int n;
        bus.req_valid         = '0;
        bus.req_valid[id]     = 1'b1;
        bus.req_a[8*id +: 8]  = a;
        bus.req_b[8*id +: 8]  = b;
        bus.req_sub[id]       = sub;
        bus.rsp_ready         = 1'b0;
        #1;
        chk("op_grant", bus.req_ready, 1 << id);
        @(posedge clk); #1;
        bus.req_valid = '0;
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("op_latency", n, 2);
        chk("op_sum", bus.rsp_sum, es);
        chk("op_id", bus.rsp_id, id);
        chk("op_ovf", bus.rsp_ovf, eo);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int got [5];
        int want [5];
        int k, cyc, ops, n, seen, gr;
        logic [NREQ-1:0] g;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single add with overflow, then subtract with and without borrow
        do_op(0, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
        do_op(2, 8'h05, 8'h09, 1'b1, 9'h0FC, 1'b0);
        do_op(2, 8'h09, 8'h05, 1'b1, 9'h104, 1'b0);

        // round-robin order from a fresh pointer
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = 8'($urandom_range(0, 255));
            bus.req_b[8*i +: 8] = 8'($urandom_range(0, 255));
            bus.req_sub[i]      = 1'($urandom_range(0, 1));
            got[i] = -1;
        end
        got[4] = -1;
        want = '{0, 1, 2, 3, 0};
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            #1;
            if (bus.req_ready != 0) begin
                for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) got[k] = j;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.req_valid = '0;
        for (int i = 0; i < 5; i++) chk("rr_order", got[i], want[i]);
        wait_idle();

        // backpressure: result held, no grant while held
        bus.rsp_ready        = 1'b0;
        bus.req_valid        = 4'b1000;
        bus.req_a[8*3 +: 8]  = 8'h40;
        bus.req_b[8*3 +: 8]  = 8'h40;
        bus.req_sub[3]       = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_sum", bus.rsp_sum, 9'h080);
            chk("bp_id", bus.rsp_id, 3);
            chk("bp_ovf", bus.rsp_ovf, 1);
            chk("bp_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", bus.rsp_valid, 0);
        chk("bp_next_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("bp_granted", bus.busy, 1);
        wait_idle();

        // reset during CALC, then re-issue
        bus.rsp_ready        = 1'b1;
        bus.req_valid        = 4'b0001;
        bus.req_a[8*0 +: 8]  = 8'h10;
        bus.req_b[8*0 +: 8]  = 8'h20;
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_busy_rst", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid        = 4'b0011;
        bus.req_a[8*1 +: 8]  = 8'h80;
        bus.req_b[8*1 +: 8]  = 8'h80;
        bus.req_sub[1]       = 1'b0;
        #1;
        chk("mid_ptr_zero", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        seen = 0;
        gr = 0;
        n = 0;
        while (seen == 0 && n < 20) begin
            #1;
            if (bus.req_ready[1]) gr = 1;
            @(posedge clk); #1;
            if (gr != 0) bus.req_valid[1] = 1'b0;
            if (bus.rsp_valid && bus.rsp_id == 1) begin
                chk("mid_req1_sum", bus.rsp_sum, 9'h100);
                chk("mid_req1_ovf", bus.rsp_ovf, 1);
                seen = 1;
            end
            n++;
        end
        chk("mid_req1_done", seen, 1);
        bus.req_valid = '0;
        wait_idle();

        // randomized traffic
        ops = 0;
        cyc = 0;
        while (ops < 10000 && cyc < 80000) begin
            @(negedge clk);
            g = bus.req_ready;
            if (g != 0) ops++;
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus.req_valid[i]    = 1'b1;
                        bus.req_a[8*i +: 8] = 8'($urandom_range(0, 255));
                        bus.req_b[8*i +: 8] = 8'($urandom_range(0, 255));
                        bus.req_sub[i]      = 1'($urandom_range(0, 1));
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        chk("random_ops", ops, 10000);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("answered_once", answered + dropped, issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
